flow_ctrl_unit: RTL and testbench
=================================

# flow_ctrl_unit

Control-flow responder paired with the fetch unit: consumes the fetched instruction word and drives the fetch unit's `init_ctrl`, `branch_ctrl`, `jump_ctrl`, `done_ctrl`, `jump_val` and `branch_val` inputs. It also owns the architectural `$branch` register and squashes the two instructions fetched in the shadow of a taken transfer. It sits between the instruction ROM output and the fetch unit.

## Interface
- `INIT_CYCLES`, 2: cycles `init_ctrl` is held high after reset; must be at least 1.
- `SHADOW`, 2: instructions squashed after a taken branch or jump; fixed by fetch timing.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instruction`  in  9  instruction word addressed by the fetch unit's `instruction_number`.
- `cond_flag`  in  1  ALU branch condition, sampled in the same cycle a BR is decoded.
- `init_ctrl`  out  1  forces fetch PC to 0.
- `branch_ctrl`  out  1  fetch adds `branch_val` to its PC.
- `jump_ctrl`  out  1  fetch loads `jump_val`.
- `done_ctrl`  out  1  program finished.
- `jump_val`  out  8  absolute jump target.
- `branch_val`  out  8  current `$branch` register contents.
- `instr_kill`  out  1  datapath must suppress all side effects of the current instruction.

## Operation
- Decode fields: opcode = `instruction[8:6]`; imm6 = `instruction[5:0]`.
- Opcodes:
  - SETBR (3'b101): `$branch` <= sign-extended imm6.
  - BR (3'b110): taken if `cond_flag`=1.
  - JMP (3'b111): `jump_val` <= {2'b00, imm6}.
  - HALT (3'b100).
  - All other opcodes are ignored by this block.
- States:
  - INIT: `init_ctrl`=1. Stays for INIT_CYCLES cycles via a down-counter, then goes to RUN.
  - RUN: decodes every cycle.
    - Taken BR: `branch_ctrl`=1 for one cycle, then FLUSH.
    - JMP: `jump_ctrl`=1 for one cycle, then FLUSH.
    - HALT: go to HALT.
    - Untaken BR, SETBR, other opcodes: stay in RUN.
  - FLUSH: squashes SHADOW instructions using a shadow counter, then returns to RUN. Instructions decoded here have no effect (SETBR, BR, JMP and HALT are all ignored).
  - HALT: `done_ctrl`=1, held until reset. No further decode.
- `instr_kill` = 1 in INIT, FLUSH and HALT, and in the cycle `branch_ctrl` or `jump_ctrl` is high.
- Branch target as seen by software = BR address + 2 + `$branch`, mod 256. The fetch unit's 8-bit adder wraps; there is no overflow detection.
- `branch_val` always reflects `$branch`. `jump_val` holds its last JMP value.
- BR immediately after SETBR uses the new `$branch` value; no forwarding is needed.

## Timing
- Reset values:
  - State = INIT, INIT counter = INIT_CYCLES-1, shadow counter = 0.
  - `$branch` = 0, `jump_val` = 0.
  - `init_ctrl` = 1; `branch_ctrl`, `jump_ctrl`, `done_ctrl` = 0; `instr_kill` = 1.
- All control outputs are registered: decode in cycle N drives the output in cycle N+1, and fetch acts at the end of N+1.
- `branch_ctrl` and `jump_ctrl` are single-cycle pulses and never high together.
- First RUN cycle decodes instruction 0.
- Reset asserted in any state (including mid-FLUSH or HALT) returns to INIT immediately and drops the transfer and done outputs asynchronously.

## Configuration
- `FLOW_STATS_EN`
  - Defined: adds output `xfer_count[15:0]`, counting taken BR plus JMP. Reset value 0; saturates at 16'hFFFF; squashed instructions are not counted.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `flow_pkg`: opcode constants, state enum (INIT/RUN/FLUSH/HALT), instruction and PC widths, SHADOW default.
- One combinational sub-module, `flow_decode`: instruction in; is_setbr/is_br/is_jmp/is_halt and imm6 out.

## Test plan
- Reset with INIT_CYCLES=2 -> `init_ctrl` high for exactly 2 cycles after release; `instr_kill`=1 during INIT; then RUN.
- SETBR imm6=6'h3E, then BR with `cond_flag`=1 -> `branch_val`=8'hFE; one-cycle `branch_ctrl`; next 2 instructions killed.
- BR with `cond_flag`=0 -> no `branch_ctrl`, no kill; the following SETBR takes effect.
- JMP imm6=6'h15 -> `jump_val`=8'h15; one-cycle `jump_ctrl`; a HALT placed in the shadow is ignored.
- HALT in RUN -> `done_ctrl` high the next cycle and held; assert reset mid-HALT -> `done_ctrl` drops asynchronously and state returns to INIT.
- `FLOW_STATS_EN` with 3 taken transfers plus 1 untaken BR -> `xfer_count`=3; preload near 16'hFFFF -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared constants and types for the control-flow responder (flow_ctrl_unit).
// Optional FLOW_STATS_EN build adds a transfer counter to the top level.
package flow_pkg;

    localparam int unsigned InstrW        = 9;
    localparam int unsigned PcW           = 8;
    localparam int unsigned ImmW          = 6;
    localparam int unsigned OpW           = 3;
    localparam int unsigned ShadowDefault = 2;
    localparam int unsigned StatsW        = 16;

    localparam logic [OpW-1:0] OpHalt  = 3'b100;
    localparam logic [OpW-1:0] OpSetbr = 3'b101;
    localparam logic [OpW-1:0] OpBr    = 3'b110;
    localparam logic [OpW-1:0] OpJmp   = 3'b111;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StFlush,
        StHalt
    } flow_state_e;

    function automatic logic [PcW-1:0] sext_imm(input logic [ImmW-1:0] imm);
        return {{(PcW-ImmW){imm[ImmW-1]}}, imm};
    endfunction

    function automatic logic [PcW-1:0] zext_imm(input logic [ImmW-1:0] imm);
        return {{(PcW-ImmW){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/flow_decode.sv
// Combinational opcode decode for flow_ctrl_unit; opcodes outside the
// control-flow set leave every flag low.
module flow_decode
    import flow_pkg::*;
(
    input  logic [InstrW-1:0] instruction,
    output logic              is_setbr,
    output logic              is_br,
    output logic              is_jmp,
    output logic              is_halt,
    output logic [ImmW-1:0]   imm6
);

    logic [OpW-1:0] w_opcode;

    assign w_opcode = instruction[InstrW-1 -: OpW];
    assign imm6     = instruction[ImmW-1:0];

    assign is_setbr = (w_opcode == OpSetbr);
    assign is_br    = (w_opcode == OpBr);
    assign is_jmp   = (w_opcode == OpJmp);
    assign is_halt  = (w_opcode == OpHalt);

endmodule

// File: rtl/flow_ctrl_unit.sv
// Control-flow responder driving the fetch unit: INIT/RUN/FLUSH/HALT FSM with
// registered controls. FLOW_STATS_EN adds a saturating taken-transfer counter.
module flow_ctrl_unit
    import flow_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned SHADOW      = ShadowDefault
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [InstrW-1:0] instruction,
    input  logic              cond_flag,
    output logic              init_ctrl,
    output logic              branch_ctrl,
    output logic              jump_ctrl,
    output logic              done_ctrl,
    output logic [PcW-1:0]    jump_val,
    output logic [PcW-1:0]    branch_val,
    output logic              instr_kill
`ifdef FLOW_STATS_EN
    ,
    output logic [StatsW-1:0] xfer_count
`endif
);

    localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned ShW   = (SHADOW > 1) ? $clog2(SHADOW) : 1;
    localparam logic [InitW-1:0] InitLoad = InitW'(INIT_CYCLES - 1);
    localparam logic [ShW-1:0]   ShLoad   = ShW'(SHADOW - 1);

    logic            w_is_setbr;
    logic            w_is_br;
    logic            w_is_jmp;
    logic            w_is_halt;
    logic [ImmW-1:0] w_imm6;
    logic            w_taken;
    logic            w_xfer;

    flow_state_e     r_state;
    logic [InitW-1:0] r_init_cnt;
    logic [ShW-1:0]  r_shadow_cnt;
    logic [PcW-1:0]  r_branch;
    logic [PcW-1:0]  r_jump_val;
    logic            r_init;
    logic            r_br;
    logic            r_jmp;
    logic            r_done;
    logic            r_kill;

    flow_decode u_decode (
        .instruction (instruction),
        .is_setbr    (w_is_setbr),
        .is_br       (w_is_br),
        .is_jmp      (w_is_jmp),
        .is_halt     (w_is_halt),
        .imm6        (w_imm6)
    );

    assign w_taken = w_is_br & cond_flag;
    // Only a live RUN-state decode may redirect fetch; shadow slots never do.
    assign w_xfer  = (r_state == StRun) & (w_taken | w_is_jmp);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StInit;
            r_init_cnt   <= InitLoad;
            r_shadow_cnt <= '0;
            r_branch     <= '0;
            r_jump_val   <= '0;
            r_init       <= 1'b1;
            r_br         <= 1'b0;
            r_jmp        <= 1'b0;
            r_done       <= 1'b0;
            r_kill       <= 1'b1;
        end else begin
            r_br  <= 1'b0;
            r_jmp <= 1'b0;
            unique case (r_state)
                StInit: begin
                    if (r_init_cnt != '0) begin
                        r_init_cnt <= r_init_cnt - 1'b1;
                    end else begin
                        r_state <= StRun;
                        r_init  <= 1'b0;
                        r_kill  <= 1'b0;
                    end
                end
                StRun: begin
                    if (w_is_setbr) begin
                        r_branch <= sext_imm(w_imm6);
                    end
                    if (w_is_jmp) begin
                        r_jump_val   <= zext_imm(w_imm6);
                        r_jmp        <= 1'b1;
                        r_kill       <= 1'b1;
                        r_shadow_cnt <= ShLoad;
                        r_state      <= StFlush;
                    end else if (w_taken) begin
                        r_br         <= 1'b1;
                        r_kill       <= 1'b1;
                        r_shadow_cnt <= ShLoad;
                        r_state      <= StFlush;
                    end else if (w_is_halt) begin
                        r_done  <= 1'b1;
                        r_kill  <= 1'b1;
                        r_state <= StHalt;
                    end
                end
                StFlush: begin
                    // The pulse cycle is the first shadow slot, so the count starts at SHADOW-1.
                    if (r_shadow_cnt != '0) begin
                        r_shadow_cnt <= r_shadow_cnt - 1'b1;
                    end else begin
                        r_kill  <= 1'b0;
                        r_state <= StRun;
                    end
                end
                StHalt: begin
                    r_done <= 1'b1;
                    r_kill <= 1'b1;
                end
                default: begin
                    r_state <= StInit;
                end
            endcase
        end
    end

    assign init_ctrl   = r_init;
    assign branch_ctrl = r_br;
    assign jump_ctrl   = r_jmp;
    assign done_ctrl   = r_done;
    assign jump_val    = r_jump_val;
    assign branch_val  = r_branch;
    assign instr_kill  = r_kill;

`ifdef FLOW_STATS_EN
    logic [StatsW-1:0] r_xfer_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_xfer_count <= '0;
        end else if (w_xfer && (r_xfer_count != {StatsW{1'b1}})) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign xfer_count = r_xfer_count;
`else
    logic w_unused_xfer;
    assign w_unused_xfer = w_xfer;
`endif

    a_xfer_exclusive: assert property (
        @(posedge clock) disable iff (!reset_n) !(branch_ctrl && jump_ctrl));

    a_done_sticky: assert property (
        @(posedge clock) disable iff (!reset_n) done_ctrl |=> done_ctrl);

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Bench for flow_ctrl_unit: vector table through a one-deep scoreboard queue,
// then hand-written reset/flush/saturation sequences (FLOW_STATS_EN aware).
module tb_flow_ctrl_unit;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] instruction = '0;
    logic       cond_flag = 1'b0;
    logic       init_ctrl;
    logic       branch_ctrl;
    logic       jump_ctrl;
    logic       done_ctrl;
    logic [7:0] jump_val;
    logic [7:0] branch_val;
    logic       instr_kill;
`ifdef FLOW_STATS_EN
    logic [15:0] xfer_count;
`endif

    flow_ctrl_unit #(
        .INIT_CYCLES (2),
        .SHADOW      (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .cond_flag   (cond_flag),
        .init_ctrl   (init_ctrl),
        .branch_ctrl (branch_ctrl),
        .jump_ctrl   (jump_ctrl),
        .done_ctrl   (done_ctrl),
        .jump_val    (jump_val),
        .branch_val  (branch_val),
        .instr_kill  (instr_kill)
`ifdef FLOW_STATS_EN
        ,
        .xfer_count  (xfer_count)
`endif
    );

    always #5 clock = ~clock;

    // {init, branch, jump, done, kill, branch_val, jump_val}
    typedef struct packed {
        logic       init;
        logic       br;
        logic       jmp;
        logic       done;
        logic       kill;
        logic [7:0] bval;
        logic [7:0] jval;
    } exp_t;

    typedef struct {
        logic [8:0] instr;
        logic       cond;
        exp_t       want;
    } vec_t;

    localparam int NumVec = 18;
    localparam exp_t ResetExp = exp_t'({5'b10001, 8'h00, 8'h00});

    vec_t vecs [NumVec];
    exp_t sb_q [$];
    int   sb_id [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [8:0] instr, input logic cond,
                                input logic [4:0] flags, input logic [7:0] bval,
                                input logic [7:0] jval);
        vec_t v;
        v.instr = instr;
        v.cond  = cond;
        v.want  = exp_t'({flags, bval, jval});
        return v;
    endfunction

    function automatic exp_t sample();
        return exp_t'({init_ctrl, branch_ctrl, jump_ctrl, done_ctrl, instr_kill,
                       branch_val, jump_val});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        int   id;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            id = sb_id.pop_front();
            check($sformatf("vec%0d", id), 32'(sample()), 32'(e));
        end
    endtask

    task automatic apply(input int k);
        instruction = vecs[k].instr;
        cond_flag   = vecs[k].cond;
        sb_q.push_back(vecs[k].want);
        sb_id.push_back(k);
    endtask

    task automatic drive(input logic [8:0] instr, input logic cond);
        instruction = instr;
        cond_flag   = cond;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(9'h100, 1'b0, 5'b10001, 8'h00, 8'h00); // HALT during INIT: ignored
        vecs[1]  = mk(9'h1FF, 1'b0, 5'b00000, 8'h00, 8'h00); // JMP during INIT: ignored
        vecs[2]  = mk(9'h17E, 1'b0, 5'b00000, 8'hFE, 8'h00); // SETBR 3E, first RUN decode
        vecs[3]  = mk(9'h180, 1'b1, 5'b01001, 8'hFE, 8'h00); // BR taken
        vecs[4]  = mk(9'h141, 1'b1, 5'b00001, 8'hFE, 8'h00); // shadow SETBR ignored
        vecs[5]  = mk(9'h1FF, 1'b1, 5'b00000, 8'hFE, 8'h00); // shadow JMP ignored
        vecs[6]  = mk(9'h180, 1'b0, 5'b00000, 8'hFE, 8'h00); // BR untaken
        vecs[7]  = mk(9'h145, 1'b0, 5'b00000, 8'h05, 8'h00); // SETBR 05 after untaken BR
        vecs[8]  = mk(9'h1D5, 1'b0, 5'b00101, 8'h05, 8'h15); // JMP 15
        vecs[9]  = mk(9'h100, 1'b0, 5'b00001, 8'h05, 8'h15); // shadow HALT ignored
        vecs[10] = mk(9'h180, 1'b1, 5'b00000, 8'h05, 8'h15); // shadow BR ignored
        vecs[11] = mk(9'h0FF, 1'b1, 5'b00000, 8'h05, 8'h15); // foreign opcode
        vecs[12] = mk(9'h1EA, 1'b0, 5'b00101, 8'h05, 8'h2A); // JMP 2A
        vecs[13] = mk(9'h000, 1'b0, 5'b00001, 8'h05, 8'h2A);
        vecs[14] = mk(9'h000, 1'b0, 5'b00000, 8'h05, 8'h2A);
        vecs[15] = mk(9'h100, 1'b0, 5'b00011, 8'h05, 8'h2A); // HALT
        vecs[16] = mk(9'h17F, 1'b0, 5'b00011, 8'h05, 8'h2A); // SETBR in HALT ignored
        vecs[17] = mk(9'h1C1, 1'b1, 5'b00011, 8'h05, 8'h2A); // JMP in HALT ignored

        @(negedge clock);
        @(negedge clock);
        check("reset_state", 32'(sample()), 32'(ResetExp));
`ifdef FLOW_STATS_EN
        check("reset_xfer", 32'(xfer_count), 32'h0);
`endif
        reset_n = 1'b1;
        apply(0);
        for (int k = 1; k < NumVec; k++) begin
            @(negedge clock);
            pop_check();
            apply(k);
        end
        @(negedge clock);
        pop_check();
`ifdef FLOW_STATS_EN
        check("xfer_count_3", 32'(xfer_count), 32'h3);
`endif

        // Asynchronous reset while halted.
        #2 reset_n = 1'b0;
        #1 check("reset_halt", 32'(sample()), 32'(ResetExp));
`ifdef FLOW_STATS_EN
        check("reset_halt_xfer", 32'(xfer_count), 32'h0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        drive(9'h1D5, 1'b0);
        @(negedge clock);
        check("init_cycle1", 32'({init_ctrl, instr_kill}), 32'b11);
        @(negedge clock);
        check("init_cycle2_run", 32'({init_ctrl, instr_kill, jump_ctrl}), 32'b000);
        drive(9'h14A, 1'b0); // SETBR 0A as instruction 0
        @(negedge clock);
        check("first_run_setbr", 32'(branch_val), 32'h0A);
        drive(9'h180, 1'b1);
        @(negedge clock);
        check("br_pulse", 32'({branch_ctrl, instr_kill, branch_val}), 32'({2'b11, 8'h0A}));
        drive(9'h000, 1'b0);

        // Asynchronous reset inside the flush window.
        #2 reset_n = 1'b0;
        #1 check("reset_flush", 32'(sample()), 32'(ResetExp));

        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
`ifdef FLOW_STATS_EN
        force dut.r_xfer_count = 16'hFFFE;
        #1 release dut.r_xfer_count;
`endif
        drive(9'h1C1, 1'b0);
        @(negedge clock);
        check("jmp_after_reinit", 32'({jump_ctrl, jump_val}), 32'({1'b1, 8'h01}));
`ifdef FLOW_STATS_EN
        check("xfer_to_max", 32'(xfer_count), 32'hFFFF);
`endif
        drive(9'h000, 1'b0);
        @(negedge clock);
        @(negedge clock);
        drive(9'h1C2, 1'b0);
        @(negedge clock);
        check("jmp_again", 32'({jump_ctrl, jump_val}), 32'({1'b1, 8'h02}));
`ifdef FLOW_STATS_EN
        check("xfer_saturate", 32'(xfer_count), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
